// File: rtl/fetch_sched_pkg.sv
// Shared definitions for the fetch scheduler and the aligner: FSM states,
// fetch-error codes carried in the IFB entry info, and the info builder.
package fetch_sched_pkg;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_FETCH,
    FS_DRAIN
  } fsched_state_t;

  // 3-bit fetch status codes, also decoded by the aligner
  localparam logic [2:0] FETCH_VALID = 3'b000;
  localparam logic [2:0] FETCH_BSERR = 3'b011;

  // Info driven while no entry is being pushed: nop set, everything else clear
  localparam logic [4:0] INFO_IDLE = 5'b00001;

  // IFB entry info = {ferr[2:0], lp_invalid, nop}
  function automatic logic [4:0] make_info(input logic rerr, input logic unal);
    return {(rerr ? FETCH_BSERR : FETCH_VALID), unal, 1'b0};
  endfunction

endpackage

// File: rtl/fetch_sched_if.sv
// Fetch scheduler bus bundle: redirect/halt control, instruction-bus read
// channel and IFB write port. The master side is the scheduler itself.
interface fetch_sched_if #(
  parameter int IFB_DEPTH = 4
);
  localparam int FREE_W = $clog2(IFB_DEPTH + 1);

  logic              flush;
  logic [31:0]       flush_addr;
  logic              halt;
  logic              req;
  logic [31:0]       addr;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              rerr;
  logic [FREE_W-1:0] ifb_free;
  logic              ifb_push;
  logic [31:0]       ifb_instr;
  logic [4:0]        ifb_info;
  logic              busy;

  modport master (
    input  flush, flush_addr, halt, gnt, rvalid, rdata, rerr, ifb_free,
    output req, addr, ifb_push, ifb_instr, ifb_info, busy
  );

  modport slave (
    output flush, flush_addr, halt, gnt, rvalid, rdata, rerr, ifb_free,
    input  req, addr, ifb_push, ifb_instr, ifb_info, busy
  );

endinterface

// File: rtl/fetch_sched_credit.sv
// Outstanding-read bookkeeping: accepts responses only when something is in
// flight, computes the next outstanding count and the issue credit check.
module fetch_sched_credit #(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 2,
  parameter int FREE_W  = 3
) (
  input  logic [CNT_W-1:0]  out_cnt,
  input  logic              push_pending,
  input  logic [FREE_W-1:0] ifb_free,
  input  logic              req_fire,
  input  logic              rvalid,
  output logic              rsp_acc,
  output logic              credit_ok,
  output logic [CNT_W-1:0]  out_cnt_next
);
  localparam int SUM_W = ((CNT_W > FREE_W) ? CNT_W : FREE_W) + 1;

  logic [SUM_W-1:0] inflight;

  // A response with nothing outstanding is a protocol error and is ignored
  assign rsp_acc = rvalid & (out_cnt != '0);

  // Reads in flight plus the entry being pushed must stay below free space
  assign inflight  = SUM_W'(out_cnt) + SUM_W'(push_pending);
  assign credit_ok = (out_cnt < CNT_W'(MAX_OUT)) && (inflight < SUM_W'(ifb_free));

  assign out_cnt_next = (req_fire && !rsp_acc) ? out_cnt + 1'b1 :
                        (!req_fire && rsp_acc) ? out_cnt - 1'b1 : out_cnt;

endmodule

// File: rtl/fetch_sched.sv
// Fetch scheduler: issues word-aligned instruction reads under an IFB credit
// check, drops responses made stale by a redirect and pushes the surviving
// ones into the IFB one cycle after they arrive.
module fetch_sched
  import fetch_sched_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h8000_0000,
  parameter int          MAX_OUT   = 2,
  parameter int          IFB_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_sched_if.master bus
);
  localparam int          CNT_W   = $clog2(MAX_OUT + 1);
  localparam int          FREE_W  = $clog2(IFB_DEPTH + 1);
  localparam logic [31:0] BOOT_PC = {BOOT_ADDR[31:2], 2'b00};

  fsched_state_t    state;
  logic [31:0]      pc;
  logic             unal;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] kill_cnt;
  logic [CNT_W-1:0] out_cnt_next;
  logic             req_lock;
  logic             vld_p1;
  logic [31:0]      instr_p1;
  logic [4:0]       info_p1;
  logic [31:0]      redirect;
  logic             req;
  logic             req_fire;
  logic             rsp_acc;
  logic             credit_ok;
  logic             push;
  logic             kill_rsp;
  logic             push_acc;

  fetch_sched_credit #(
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W),
    .FREE_W  (FREE_W)
  ) u_credit (
    .out_cnt      (out_cnt),
    .push_pending (push),
    .ifb_free     (bus.ifb_free),
    .req_fire     (req_fire),
    .rvalid       (bus.rvalid),
    .rsp_acc      (rsp_acc),
    .credit_ok    (credit_ok),
    .out_cnt_next (out_cnt_next)
  );

  assign redirect = bus.flush_addr;
  assign push     = vld_p1 & ~bus.flush;

  // req_lock keeps a raised request (and pc) steady until granted, even if
  // halt rises meanwhile; only flush or reset may withdraw it.
  assign req      = (state == FS_FETCH) & ~bus.flush & (req_lock | (~bus.halt & credit_ok));
  assign req_fire = req & bus.gnt;

  // Responses in the flush cycle or owed to an earlier flush are dropped
  assign kill_rsp = rsp_acc & (bus.flush | (kill_cnt != '0));
  assign push_acc = rsp_acc & ~kill_rsp;

  assign bus.req       = req;
  assign bus.addr      = pc;
  assign bus.ifb_push  = push;
  assign bus.ifb_instr = instr_p1;
  assign bus.ifb_info  = push ? info_p1 : INFO_IDLE;
  assign bus.busy      = (out_cnt != '0) | (state != FS_FETCH);

  // Scheduler state, pc, alignment flag and outstanding/kill counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FS_BOOT;
      pc       <= BOOT_PC;
      unal     <= 1'b0;
      out_cnt  <= '0;
      kill_cnt <= '0;
      req_lock <= 1'b0;
    end else begin
      out_cnt  <= out_cnt_next;
      req_lock <= req & ~bus.gnt;
      if (req_fire) pc <= pc + 32'd4;
      if (push_acc) unal <= 1'b0;
      if (rsp_acc && (kill_cnt != '0)) kill_cnt <= kill_cnt - 1'b1;
      case (state)
        FS_BOOT: begin
          state <= FS_FETCH;
          pc    <= BOOT_PC;
          unal  <= BOOT_ADDR[1];
        end
        FS_DRAIN: if (out_cnt == '0) state <= FS_FETCH;
        FS_FETCH: ;
        default:  state <= FS_BOOT;
      endcase
      if (bus.flush) begin
        state    <= (out_cnt_next != '0) ? FS_DRAIN : FS_FETCH;
        pc       <= redirect & 32'hFFFF_FFFC;
        unal     <= redirect[1];
        kill_cnt <= out_cnt_next;
      end
    end
  end

  // ---- p1: accepted response registered for the IFB write ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      info_p1  <= INFO_IDLE;
    end else begin
      vld_p1 <= push_acc;
      if (push_acc) begin
        instr_p1 <= bus.rdata;
        info_p1  <= make_info(bus.rerr, unal);
      end
    end
  end

endmodule
